// File: rtl/ysyx_25040111_rr_xbar_if.sv
// Bus bundle for the round-robin crossbar: N_MST requesting masters on one side
// (m_*), the single LSU memory port on the other (s_*).
//  modport master : crossbar view - arbitrates the masters, drives the slave request
//  modport slave  : environment view - the masters and the LSU port
// Master i occupies [i*AW +: AW] of m_addr, [i*8 +: 8] of m_len,
// [i*DW +: DW] of m_wdata and [i*DW/8 +: DW/8] of m_wstrb.
interface ysyx_25040111_rr_xbar_if #(
    parameter int N_MST = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    logic [N_MST-1:0]        m_valid;
    logic [N_MST-1:0]        m_ready;
    logic [N_MST-1:0]        m_write;
    logic [N_MST*AW-1:0]     m_addr;
    logic [N_MST*8-1:0]      m_len;
    logic [N_MST*DW-1:0]     m_wdata;
    logic [N_MST*DW/8-1:0]   m_wstrb;
    logic [N_MST-1:0]        m_rvalid;
    logic [N_MST-1:0]        m_rready;
    logic [DW-1:0]           m_rdata;
    logic                    m_rlast;
    logic [N_MST-1:0]        m_bvalid;
    logic                    m_err;

    logic                    s_avalid;
    logic                    s_aready;
    logic                    s_write;
    logic [AW-1:0]           s_addr;
    logic [7:0]              s_len;
    logic [DW-1:0]           s_wdata;
    logic [DW/8-1:0]         s_wstrb;
    logic                    s_rvalid;
    logic                    s_rready;
    logic [DW-1:0]           s_rdata;
    logic                    s_rlast;
    logic                    s_bvalid;
    logic                    s_bready;

    modport master (
        input  m_valid, m_write, m_addr, m_len, m_wdata, m_wstrb, m_rready,
               s_aready, s_rvalid, s_rdata, s_rlast, s_bvalid,
        output m_ready, m_rvalid, m_rdata, m_rlast, m_bvalid, m_err,
               s_avalid, s_write, s_addr, s_len, s_wdata, s_wstrb, s_rready, s_bready
    );

    modport slave (
        output m_valid, m_write, m_addr, m_len, m_wdata, m_wstrb, m_rready,
               s_aready, s_rvalid, s_rdata, s_rlast, s_bvalid,
        input  m_ready, m_rvalid, m_rdata, m_rlast, m_bvalid, m_err,
               s_avalid, s_write, s_addr, s_len, s_wdata, s_wstrb, s_rready, s_bready
    );
endinterface

// File: rtl/ysyx_25040111_rr_xbar.sv
// N-master to 1-slave round-robin arbiter in front of the LSU memory port.
// One transaction outstanding; the grant holds for a whole read burst or a
// single write. States: IDLE -> REQ -> (RD | WR) -> IDLE.
// Ports:
//  clock : system clock
//  reset : asynchronous, active-low reset
//  bus   : ysyx_25040111_rr_xbar_if.master (m_* master side, s_* LSU side)
// Optional feature: define ARB_TIMEOUT_EN to enable an 8-bit watchdog that
// answers the granted master with an error response after TIMEOUT cycles
// without a slave handshake and aborts the transaction.
module ysyx_25040111_rr_xbar #(
    parameter int N_MST   = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    ysyx_25040111_rr_xbar_if.master bus
);
    localparam int PW = $clog2(N_MST);

    if (N_MST < 2 || N_MST > 8) begin : g_chk_nmst
        $error("N_MST must be in 2..8");
    end
    if (DW % 8 != 0) begin : g_chk_dw
        $error("DW must be a multiple of 8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_chk_timeout
        $error("TIMEOUT must fit the 8-bit watchdog");
    end

    typedef enum logic [1:0] {IDLE, REQ, RD, WR} state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant;
    logic [PW-1:0] grant_nxt;
    logic [PW-1:0] pick;
    logic          pick_vld;
    logic [PW:0]   cand;
    logic          timeout;

    // First requesting master at or after rr_ptr, wrapping at N_MST.
    always_comb begin
        pick     = rr_ptr;
        pick_vld = 1'b0;
        cand     = '0;
        for (int unsigned off = 0; off < N_MST; off++) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(off);
            if (cand >= (PW+1)'(N_MST)) begin
                cand = cand - (PW+1)'(N_MST);
            end
            if (!pick_vld && bus.m_valid[cand[PW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = cand[PW-1:0];
            end
        end
        grant_nxt = (grant == PW'(N_MST-1)) ? '0 : grant + PW'(1);
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       slv_hs;

    always_comb begin
        slv_hs  = ((state == REQ) && bus.s_aready) ||
                  ((state == RD)  && bus.s_rvalid && bus.s_rready) ||
                  ((state == WR)  && bus.s_bvalid);
        timeout = (state != IDLE) && (to_cnt == 8'(TIMEOUT));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state == IDLE || slv_hs) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 8'd1;
        end
    end
`else
    always_comb timeout = 1'b0;
`endif

    // Response path is a pass-through so read beats see no added latency;
    // everything is forced idle outside the owning state, which also makes all
    // outputs zero while reset holds the FSM in IDLE.
    always_comb begin
        bus.m_ready  = '0;
        bus.m_rvalid = '0;
        bus.m_bvalid = '0;
        bus.m_rdata  = '0;
        bus.m_rlast  = 1'b0;
        bus.m_err    = 1'b0;
        bus.s_avalid = 1'b0;
        bus.s_rready = 1'b0;
        bus.s_bready = 1'b0;
        case (state)
            IDLE: begin
                if (reset && pick_vld) begin
                    bus.m_ready[pick] = 1'b1;
                end
            end
            REQ: begin
                if (timeout) begin
                    bus.m_err = 1'b1;
                    if (bus.s_write) begin
                        bus.m_bvalid[grant] = 1'b1;
                    end else begin
                        bus.m_rvalid[grant] = 1'b1;
                        bus.m_rlast         = 1'b1;
                    end
                end else begin
                    bus.s_avalid = 1'b1;
                end
            end
            RD: begin
                if (timeout) begin
                    bus.m_rvalid[grant] = 1'b1;
                    bus.m_rlast         = 1'b1;
                    bus.m_err           = 1'b1;
                end else begin
                    bus.m_rvalid[grant] = bus.s_rvalid;
                    bus.m_rdata         = bus.s_rdata;
                    bus.m_rlast         = bus.s_rvalid & bus.s_rlast;
                    bus.s_rready        = bus.m_rready[grant];
                end
            end
            WR: begin
                if (timeout) begin
                    bus.m_bvalid[grant] = 1'b1;
                    bus.m_err           = 1'b1;
                end else begin
                    bus.m_bvalid[grant] = bus.s_bvalid;
                    bus.s_bready        = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            bus.s_write <= 1'b0;
            bus.s_addr  <= '0;
            bus.s_len   <= '0;
            bus.s_wdata <= '0;
            bus.s_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant       <= pick;
                        bus.s_write <= bus.m_write[pick];
                        bus.s_addr  <= bus.m_addr[int'(pick)*AW +: AW];
                        bus.s_len   <= bus.m_write[pick] ? 8'd0 : bus.m_len[int'(pick)*8 +: 8];
                        bus.s_wdata <= bus.m_wdata[int'(pick)*DW +: DW];
                        bus.s_wstrb <= bus.m_wstrb[int'(pick)*(DW/8) +: DW/8];
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (timeout) begin
                        rr_ptr <= grant_nxt;
                        state  <= IDLE;
                    end else if (bus.s_aready) begin
                        state <= bus.s_write ? WR : RD;
                    end
                end
                RD: begin
                    if (timeout || (bus.s_rvalid && bus.s_rready && bus.s_rlast)) begin
                        rr_ptr <= grant_nxt;
                        state  <= IDLE;
                    end
                end
                WR: begin
                    if (timeout || bus.s_bvalid) begin
                        rr_ptr <= grant_nxt;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25040111_rr_xbar.sv
// Directed bench for ysyx_25040111_rr_xbar with two masters.
module tb_ysyx_25040111_rr_xbar;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    ysyx_25040111_rr_xbar_if #(.N_MST(N), .AW(AW), .DW(DW)) bus ();

    ysyx_25040111_rr_xbar #(.N_MST(N), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    localparam logic [N-1:0] ONE = 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // A master must hold m_valid until it sees m_ready.
    logic [N-1:0] pend_q = '0;
    always @(posedge clock) begin
        if (reset) begin
            assert ((pend_q & ~bus.m_valid) == '0) else begin
                n_fail++;
                $error("FAIL m_valid_dropped observed=0x%0h expected=0x%0h", bus.m_valid, pend_q);
            end
        end
        pend_q <= bus.m_valid & ~bus.m_ready;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic set_req(input int m, input logic wr, input logic [31:0] a,
                           input logic [7:0] l, input logic [31:0] d, input logic [3:0] s);
        bus.m_valid[m]           = 1'b1;
        bus.m_write[m]           = wr;
        bus.m_addr[m*AW +: AW]   = a;
        bus.m_len[m*8 +: 8]      = l;
        bus.m_wdata[m*DW +: DW]  = d;
        bus.m_wstrb[m*4 +: 4]    = s;
    endtask

    // Called right after inputs change at a negedge while the DUT is in IDLE.
    task automatic grant(input string tag, input logic [N-1:0] exp);
        #1 check({tag, ".m_ready"}, 64'(bus.m_ready), 64'(exp));
        @(negedge clock);
        bus.m_valid = bus.m_valid & ~exp;
        check({tag, ".m_ready_req"}, 64'(bus.m_ready), 64'(0));
    endtask

    task automatic slave_accept(input string tag, input logic wr, input logic [31:0] a,
                                input logic [7:0] l, input logic [31:0] d, input logic [3:0] s);
        #1;
        check({tag, ".s_avalid"}, 64'(bus.s_avalid), 64'(1));
        check({tag, ".s_write"},  64'(bus.s_write),  64'(wr));
        check({tag, ".s_addr"},   64'(bus.s_addr),   64'(a));
        if (wr) begin
            check({tag, ".s_wdata"}, 64'(bus.s_wdata), 64'(d));
            check({tag, ".s_wstrb"}, 64'(bus.s_wstrb), 64'(s));
        end else begin
            check({tag, ".s_len"}, 64'(bus.s_len), 64'(l));
        end
        bus.s_aready = 1'b1;
        @(negedge clock);
        bus.s_aready = 1'b0;
    endtask

    task automatic read_beats(input string tag, input int m, input int n, input logic [31:0] base);
        for (int b = 0; b < n; b++) begin
            bus.s_rvalid    = 1'b1;
            bus.s_rdata     = base + 32'(b);
            bus.s_rlast     = (b == n - 1);
            bus.m_rready    = '0;
            bus.m_rready[m] = 1'b1;
            #1;
            check({tag, ".m_rvalid"}, 64'(bus.m_rvalid), 64'(ONE << m));
            check({tag, ".m_rdata"},  64'(bus.m_rdata),  64'(base + 32'(b)));
            check({tag, ".m_rlast"},  64'(bus.m_rlast),  64'(b == n - 1));
            check({tag, ".s_rready"}, 64'(bus.s_rready), 64'(1));
            @(negedge clock);
        end
        bus.s_rvalid = 1'b0;
        bus.s_rlast  = 1'b0;
        bus.m_rready = '0;
        #1 check({tag, ".rvalid_end"}, 64'(bus.m_rvalid), 64'(0));
    endtask

    task automatic write_resp(input string tag, input int m);
        #1;
        check({tag, ".s_bready"},    64'(bus.s_bready), 64'(1));
        check({tag, ".bvalid_wait"}, 64'(bus.m_bvalid), 64'(0));
        bus.s_bvalid = 1'b1;
        #1;
        check({tag, ".m_bvalid"}, 64'(bus.m_bvalid), 64'(ONE << m));
        check({tag, ".m_err"},    64'(bus.m_err),    64'(0));
        @(negedge clock);
        bus.s_bvalid = 1'b0;
        #1;
        check({tag, ".bvalid_end"}, 64'(bus.m_bvalid), 64'(0));
        check({tag, ".bready_end"}, 64'(bus.s_bready), 64'(0));
    endtask

    logic [N-1:0] pend_m;
    logic         rq_wr   [N];
    logic [31:0]  rq_addr [N];
    logic [7:0]   rq_len  [N];
    logic [31:0]  rq_data [N];
    logic [3:0]   rq_strb [N];
    int           ptr, win, idx, beat, got;

    initial begin
        bus.m_valid = '0; bus.m_write = '0; bus.m_addr = '0; bus.m_len = '0;
        bus.m_wdata = '0; bus.m_wstrb = '0; bus.m_rready = '0;
        bus.s_aready = 1'b0; bus.s_rvalid = 1'b0; bus.s_rdata = '0;
        bus.s_rlast = 1'b0; bus.s_bvalid = 1'b0;

        // Reset state
        @(negedge clock); @(negedge clock);
        check("rst.m_ready",  64'(bus.m_ready),  64'(0));
        check("rst.s_avalid", 64'(bus.s_avalid), 64'(0));
        check("rst.s_addr",   64'(bus.s_addr),   64'(0));
        check("rst.m_err",    64'(bus.m_err),    64'(0));
        reset = 1'b1;

        // 1) m0 reads 4 beats from 0x8000_0000
        set_req(0, 1'b0, 32'h8000_0000, 8'd3, 32'h0, 4'h0);
        grant("t1", 2'b01);
        slave_accept("t1", 1'b0, 32'h8000_0000, 8'd3, 32'h0, 4'h0);
        read_beats("t1", 0, 4, 32'hA000_0000);

        // 3) rr_ptr is now 1: m1's write beats m0's simultaneous read
        set_req(0, 1'b0, 32'h0000_7000, 8'd0, 32'h0, 4'h0);
        set_req(1, 1'b1, 32'h0000_1000, 8'd0, 32'hDEAD_BEEF, 4'h3);
        grant("t3", 2'b10);
        slave_accept("t3", 1'b1, 32'h0000_1000, 8'd0, 32'hDEAD_BEEF, 4'h3);
        write_resp("t3", 1);
        grant("t3.m0", 2'b01);
        slave_accept("t3.m0", 1'b0, 32'h0000_7000, 8'd0, 32'h0, 4'h0);
        read_beats("t3.m0", 0, 1, 32'h7000_0000);

        // 2) 100 random back-to-back requests against a round-robin model
        ptr    = 1;
        pend_m = '0;
        for (int t = 0; t < 110 && (t < 100 || pend_m != '0); t++) begin
            if (t < 100) begin
                for (int i = 0; i < N; i++) begin
                    if (!pend_m[i] && ($urandom_range(0, 2) != 0 || (pend_m == '0 && i == N - 1))) begin
                        rq_wr[i]   = 1'($urandom_range(0, 1));
                        rq_addr[i] = $urandom;
                        rq_len[i]  = 8'($urandom_range(0, 2));
                        rq_data[i] = $urandom;
                        rq_strb[i] = 4'($urandom_range(1, 15));
                        set_req(i, rq_wr[i], rq_addr[i], rq_len[i], rq_data[i], rq_strb[i]);
                        pend_m[i] = 1'b1;
                    end
                end
            end
            win = -1;
            for (int k = 0; k < N; k++) begin
                idx = (ptr + k) % N;
                if (win < 0 && pend_m[idx]) win = idx;
            end
            grant("rr", ONE << win);
            pend_m[win] = 1'b0;
            slave_accept("rr", rq_wr[win], rq_addr[win], rq_len[win], rq_data[win], rq_strb[win]);
            if (rq_wr[win]) write_resp("rr", win);
            else            read_beats("rr", win, int'(rq_len[win]) + 1, rq_addr[win] ^ 32'h5A5A_0000);
            ptr = (win + 1) % N;
        end

        // 4) read with m_rready toggling; beats must arrive once each, in order
        set_req(0, 1'b0, 32'h0000_2000, 8'd3, 32'h0, 4'h0);
        grant("t4", 2'b01);
        slave_accept("t4", 1'b0, 32'h0000_2000, 8'd3, 32'h0, 4'h0);
        beat = 0;
        got  = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            bus.m_rready = '0;
            bus.m_rready[0] = (c % 2 == 1);
            bus.s_rvalid = 1'b1;
            bus.s_rdata  = 32'hB000 + 32'(beat);
            bus.s_rlast  = (beat == 3);
            #1;
            check("t4.m_rvalid", 64'(bus.m_rvalid), 64'(2'b01));
            check("t4.s_rready", 64'(bus.s_rready), 64'(c % 2 == 1));
            if (bus.m_rvalid[0] && bus.m_rready[0]) begin
                check("t4.m_rdata", 64'(bus.m_rdata), 64'(32'hB000 + 32'(got)));
                got++;
            end
            if (bus.s_rready) beat++;
            @(negedge clock);
        end
        bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0; bus.m_rready = '0;
        check("t4.beats", 64'(got), 64'(4));
        #1 check("t4.rvalid_end", 64'(bus.m_rvalid), 64'(0));

        // 5) reset during beat 2 of a 4-beat read (rr_ptr is 1 beforehand)
        set_req(0, 1'b0, 32'h0000_3000, 8'd3, 32'h0, 4'h0);
        grant("t5", 2'b01);
        slave_accept("t5", 1'b0, 32'h0000_3000, 8'd3, 32'h0, 4'h0);
        bus.s_rvalid = 1'b1; bus.s_rdata = 32'hC000; bus.m_rready = 2'b01;
        #1 @(negedge clock);
        bus.s_rdata = 32'hC001;
        set_req(0, 1'b0, 32'h0000_4000, 8'd0, 32'h0, 4'h0);
        set_req(1, 1'b1, 32'h0000_5000, 8'd0, 32'h1234_5678, 4'hF);
        #1 reset = 1'b0;
        #1;
        check("t5.m_ready",  64'(bus.m_ready),  64'(0));
        check("t5.m_rvalid", 64'(bus.m_rvalid), 64'(0));
        check("t5.m_rdata",  64'(bus.m_rdata),  64'(0));
        check("t5.m_rlast",  64'(bus.m_rlast),  64'(0));
        check("t5.m_err",    64'(bus.m_err),    64'(0));
        check("t5.m_bvalid", 64'(bus.m_bvalid), 64'(0));
        check("t5.s_avalid", 64'(bus.s_avalid), 64'(0));
        check("t5.s_rready", 64'(bus.s_rready), 64'(0));
        check("t5.s_bready", 64'(bus.s_bready), 64'(0));
        check("t5.s_addr",   64'(bus.s_addr),   64'(0));
        check("t5.s_len",    64'(bus.s_len),    64'(0));
        check("t5.s_wdata",  64'(bus.s_wdata),  64'(0));
        check("t5.s_wstrb",  64'(bus.s_wstrb),  64'(0));
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("t5.drop_rvalid", 64'(bus.m_rvalid), 64'(0));
        check("t5.drop_rready", 64'(bus.s_rready), 64'(0));
        bus.s_rvalid = 1'b0; bus.m_rready = '0;
        grant("t5.ptr0", 2'b01);
        slave_accept("t5.m0", 1'b0, 32'h0000_4000, 8'd0, 32'h0, 4'h0);
        read_beats("t5.m0", 0, 1, 32'hD000_0000);
        grant("t5.m1", 2'b10);
        slave_accept("t5.m1", 1'b1, 32'h0000_5000, 8'd0, 32'h1234_5678, 4'hF);
        write_resp("t5.m1", 1);

`ifdef ARB_TIMEOUT_EN
        // 6) silent slave: error response after 16 cycles, then normal service
        set_req(0, 1'b0, 32'h0000_6000, 8'd0, 32'h0, 4'h0);
        grant("t6", 2'b01);
        for (int k = 1; k <= 16; k++) begin
            #1;
            check("t6.wait_rvalid", 64'(bus.m_rvalid), 64'(0));
            check("t6.wait_avalid", 64'(bus.s_avalid), 64'(1));
            @(negedge clock);
        end
        #1;
        check("t6.m_rvalid", 64'(bus.m_rvalid), 64'(2'b01));
        check("t6.m_rlast",  64'(bus.m_rlast),  64'(1));
        check("t6.m_err",    64'(bus.m_err),    64'(1));
        check("t6.s_avalid", 64'(bus.s_avalid), 64'(0));
        @(negedge clock);
        #1 check("t6.idle_rvalid", 64'(bus.m_rvalid), 64'(0));
        set_req(1, 1'b1, 32'h0000_6100, 8'd0, 32'hCAFE_F00D, 4'hC);
        grant("t6.next", 2'b10);
        slave_accept("t6.next", 1'b1, 32'h0000_6100, 8'd0, 32'hCAFE_F00D, 4'hC);
        write_resp("t6.next", 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
